// File: rtl/controlador_motores.sv
// controlador_motores: two-motor sequencer (single mode or timed alternation with dead time).
// Latency: first motor enable is visible one CLK edge after ARRANQUE=1 is sampled in IDLE.
// Flow: level-driven ARRANQUE, no handshake; all outputs are registered and cleared asynchronously.
//
// Ports:
//   CLK       in   rising-edge clock
//   REINICIO  in   asynchronous active-high reset
//   ARRANQUE  in   run request (level, sampled on CLK)
//   MODO      in   0 = single (MOTOR1 only), 1 = alternating; latched on start
//   MOTOR1    out  motor 1 enable (registered)
//   MOTOR2    out  motor 2 enable (registered)
//   OCUPADO   out  high whenever the sequencer is not idle (registered)
//
// Optional feature: define SEQ_ALTERNATE_EN to swap which motor leads the
// alternation after every completed alternating session.

module controlador_motores #(
  parameter int T_RUN = 8,  // cycles a motor stays on per turn (>=1)
  parameter int T_GAP = 2,  // dead-time cycles between turns and on stop (>=1)
  parameter int CNT_W = 8   // must hold max(T_RUN,T_GAP)-1
) (
  input  logic CLK,
  input  logic REINICIO,
  input  logic ARRANQUE,
  input  logic MODO,
  output logic MOTOR1,
  output logic MOTOR2,
  output logic OCUPADO
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN_A    = 3'd1,
    GAP_AB   = 3'd2,
    RUN_B    = 3'd3,
    GAP_BA   = 3'd4,
    GAP_STOP = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(T_RUN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             modo_q, modo_d;
  logic             lead, lead_d;
  logic             motor1_d, motor2_d, ocupado_d;
  logic             lead_eff;

  // Registers: state, counter, latched mode, lead selector and the outputs.
  // Outputs are registered copies of the decode of the next state, so they
  // change on the same edge as the state and never see the inputs directly.
  always_ff @(posedge CLK or posedge REINICIO) begin
    if (REINICIO) begin
      state   <= IDLE;
      cnt     <= '0;
      modo_q  <= 1'b0;
      lead    <= 1'b0;
      MOTOR1  <= 1'b0;
      MOTOR2  <= 1'b0;
      OCUPADO <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      modo_q  <= modo_d;
      lead    <= lead_d;
      MOTOR1  <= motor1_d;
      MOTOR2  <= motor2_d;
      OCUPADO <= ocupado_d;
    end
  end

  // Next-state, counter and output decode.
  // cnt_d defaults to 0, so every state change (and every untimed hold)
  // restarts the counter; only a timed stay in the same state increments it.
  always_comb begin
    state_d   = state;
    cnt_d     = '0;
    modo_d    = modo_q;
    lead_d    = lead;
    motor1_d  = 1'b0;
    motor2_d  = 1'b0;
    ocupado_d = 1'b0;
    lead_eff  = 1'b0;

    case (state)
      IDLE: begin
        if (ARRANQUE) begin
          state_d = RUN_A;
          modo_d  = MODO;
        end
      end

      RUN_A, RUN_B: begin
        if (!ARRANQUE) begin
          state_d = GAP_STOP;
        end else if (!modo_q) begin
          // Single mode: run indefinitely, counter parked at 0.
          state_d = state;
        end else if (cnt == RUN_LAST) begin
          state_d = (state == RUN_A) ? GAP_AB : GAP_BA;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      GAP_AB, GAP_BA: begin
        if (!ARRANQUE) begin
          state_d = GAP_STOP;
        end else if (cnt == GAP_LAST) begin
          state_d = (state == GAP_AB) ? RUN_B : RUN_A;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      GAP_STOP: begin
        // ARRANQUE is deliberately ignored: the full dead time always elapses.
        if (cnt == GAP_LAST) begin
          state_d = IDLE;
`ifdef SEQ_ALTERNATE_EN
          if (modo_q) begin
            lead_d = ~lead;
          end
`endif
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Without SEQ_ALTERNATE_EN nothing ever sets lead, so it stays 0 and
    // RUN_A is always MOTOR1. Single mode ignores lead entirely.
    lead_eff = modo_d & lead_d;

    case (state_d)
      RUN_A: begin
        motor1_d = ~lead_eff;
        motor2_d = lead_eff;
      end
      RUN_B: begin
        motor1_d = lead_eff;
        motor2_d = ~lead_eff;
      end
      default: begin
        motor1_d = 1'b0;
        motor2_d = 1'b0;
      end
    endcase

    ocupado_d = (state_d != IDLE);
  end

  // Both motors must never be enabled together.
  a_no_overlap: assert property (@(posedge CLK) disable iff (REINICIO) !(MOTOR1 && MOTOR2));

endmodule

// File: tb/tb_controlador_motores.sv
// Bench for controlador_motores: directed scenarios plus random ARRANQUE/MODO
// traffic, all compared against a time-based behavioural model.
module tb_controlador_motores;

  localparam int T_RUN  = 8;
  localparam int T_GAP  = 2;
  localparam int CNT_W  = 8;
  localparam int PERIOD = 2 * (T_RUN + T_GAP);
`ifdef SEQ_ALTERNATE_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif

  logic CLK;
  logic REINICIO;
  logic ARRANQUE;
  logic MODO;
  logic MOTOR1;
  logic MOTOR2;
  logic OCUPADO;

  int errors = 0;
  int checks = 0;

  // Behavioural model: a session is "running" with elapsed time m_t since
  // the start; stopping leaves m_stop dead-time cycles before idle.
  bit m_running;
  int m_stop;
  bit m_mode;
  int m_t;
  bit m_lead;

  controlador_motores #(
    .T_RUN(T_RUN),
    .T_GAP(T_GAP),
    .CNT_W(CNT_W)
  ) dut (
    .CLK     (CLK),
    .REINICIO(REINICIO),
    .ARRANQUE(ARRANQUE),
    .MODO    (MODO),
    .MOTOR1  (MOTOR1),
    .MOTOR2  (MOTOR2),
    .OCUPADO (OCUPADO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void model_reset();
    m_running = 1'b0;
    m_stop    = 0;
    m_mode    = 1'b0;
    m_t       = 0;
    m_lead    = 1'b0;
  endfunction

  function automatic void model_step(input logic arr, input logic modo);
    if (m_stop > 0) begin
      m_stop = m_stop - 1;
      if (m_stop == 0 && m_mode && ALT) m_lead = ~m_lead;
    end else if (m_running) begin
      if (!arr) begin
        m_running = 1'b0;
        m_stop    = T_GAP;
      end else begin
        m_t = m_t + 1;
      end
    end else if (arr) begin
      m_running = 1'b1;
      m_mode    = modo;
      m_t       = 0;
    end
  endfunction

  // Expected {MOTOR1, MOTOR2, OCUPADO}.
  function automatic logic [2:0] model_out();
    int p;
    bit le;
    if (!m_running) return (m_stop > 0) ? 3'b001 : 3'b000;
    if (!m_mode) return 3'b101;
    le = m_lead;
    p  = m_t % PERIOD;
    if (p < T_RUN) return le ? 3'b011 : 3'b101;
    if (p < T_RUN + T_GAP) return 3'b001;
    if (p < 2 * T_RUN + T_GAP) return le ? 3'b101 : 3'b011;
    return 3'b001;
  endfunction

  // Stimulus only: drive inputs, take one edge, advance the model, settle.
  task automatic drive_cycle(input logic arr, input logic modo);
    ARRANQUE = arr;
    MODO     = modo;
    @(posedge CLK);
    model_step(arr, modo);
    #1;
  endtask

  task automatic apply_reset();
    REINICIO = 1'b1;
    @(posedge CLK);
    #1;
    REINICIO = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [2:0] obs;
    #1;
    obs = {MOTOR1, MOTOR2, OCUPADO};
    checks++;
    if (obs !== 3'b000) begin
      errors++;
      $display("FAIL reset_initial got=%b expected=000", obs);
    end
    for (int i = 0; i < 2; i++) begin
      ARRANQUE = 1'b0;
      @(posedge CLK);
      #1;
      obs = {MOTOR1, MOTOR2, OCUPADO};
      checks++;
      if (obs !== 3'b000) begin
        errors++;
        $display("FAIL reset_held cyc=%0d got=%b expected=000", i, obs);
      end
    end
    REINICIO = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0);
      obs = {MOTOR1, MOTOR2, OCUPADO};
      checks++;
      if (obs !== 3'b000) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%b expected=000", i, obs);
      end
    end
  endtask

  task automatic test_single();
    logic [2:0] obs;
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b1, (i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
      obs = {MOTOR1, MOTOR2, OCUPADO};
      checks++;
      if (obs !== 3'b101 || obs !== model_out()) begin
        errors++;
        $display("FAIL single cyc=%0d got=%b expected=101 model=%b", i, obs, model_out());
      end
    end
    for (int i = 0; i < T_GAP + 2; i++) begin
      drive_cycle(1'b0, 1'b0);
      obs = {MOTOR1, MOTOR2, OCUPADO};
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL single_stop cyc=%0d got=%b expected=%b", i, obs, model_out());
      end
    end
  endtask

  task automatic test_alternate();
    logic [2:0] obs;
    apply_reset();
    for (int i = 0; i < 3 * PERIOD; i++) begin
      drive_cycle(1'b1, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
      obs = {MOTOR1, MOTOR2, OCUPADO};
      checks++;
      if (obs !== model_out() || (MOTOR1 && MOTOR2)) begin
        errors++;
        $display("FAIL alternate cyc=%0d got=%b expected=%b", i, obs, model_out());
      end
    end
    for (int i = 0; i < T_GAP + 2; i++) begin
      drive_cycle(1'b0, 1'b0);
      obs = {MOTOR1, MOTOR2, OCUPADO};
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL alternate_stop cyc=%0d got=%b expected=%b", i, obs, model_out());
      end
    end
  endtask

  task automatic test_stop_in_run_b();
    logic [2:0] obs;
    apply_reset();
    // T_RUN + T_GAP + 3 edges leaves the DUT in the 3rd cycle of RUN_B.
    for (int i = 0; i < T_RUN + T_GAP + 3; i++) drive_cycle(1'b1, 1'b1);
    obs = {MOTOR1, MOTOR2, OCUPADO};
    checks++;
    if (obs !== 3'b011) begin
      errors++;
      $display("FAIL run_b_on got=%b expected=011", obs);
    end
    drive_cycle(1'b0, 1'b1);
    obs = {MOTOR1, MOTOR2, OCUPADO};
    checks++;
    if (obs !== 3'b001) begin
      errors++;
      $display("FAIL run_b_stop_edge got=%b expected=001", obs);
    end
    // ARRANQUE back high during the dead time must not extend or cancel it.
    drive_cycle(1'b1, 1'b1);
    obs = {MOTOR1, MOTOR2, OCUPADO};
    checks++;
    if (obs !== 3'b001) begin
      errors++;
      $display("FAIL run_b_gap_2 got=%b expected=001", obs);
    end
    drive_cycle(1'b1, 1'b0);
    obs = {MOTOR1, MOTOR2, OCUPADO};
    checks++;
    if (obs !== 3'b000 || obs !== model_out()) begin
      errors++;
      $display("FAIL run_b_idle got=%b expected=000", obs);
    end
    // ARRANQUE still high in IDLE restarts on the first idle cycle.
    drive_cycle(1'b1, 1'b0);
    obs = {MOTOR1, MOTOR2, OCUPADO};
    checks++;
    if (obs !== 3'b101 || obs !== model_out()) begin
      errors++;
      $display("FAIL restart_from_idle got=%b expected=101", obs);
    end
    for (int i = 0; i < T_GAP + 1; i++) drive_cycle(1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [2:0] obs;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1);
    obs = {MOTOR1, MOTOR2, OCUPADO};
    checks++;
    if (obs !== model_out()) begin
      errors++;
      $display("FAIL async_pre got=%b expected=%b", obs, model_out());
    end
    #3;
    REINICIO = 1'b1;
    #1;
    obs = {MOTOR1, MOTOR2, OCUPADO};
    checks++;
    if (obs !== 3'b000) begin
      errors++;
      $display("FAIL async_drop got=%b expected=000", obs);
    end
    #2;
    REINICIO = 1'b0;
    model_reset();
    drive_cycle(1'b1, 1'b0);
    obs = {MOTOR1, MOTOR2, OCUPADO};
    checks++;
    if (obs !== 3'b101 || obs !== model_out()) begin
      errors++;
      $display("FAIL async_restart got=%b expected=101", obs);
    end
    for (int i = 0; i < T_GAP + 1; i++) drive_cycle(1'b0, 1'b0);
  endtask

  task automatic test_lead();
    logic [2:0] obs;
    logic [2:0] want;
    apply_reset();
    for (int s = 0; s < 2; s++) begin
      drive_cycle(1'b1, 1'b1);
      obs  = {MOTOR1, MOTOR2, OCUPADO};
      want = (s == 1 && ALT) ? 3'b011 : 3'b101;
      checks++;
      if (obs !== want || obs !== model_out()) begin
        errors++;
        $display("FAIL lead_session%0d got=%b expected=%b", s, obs, want);
      end
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0);
      for (int i = 0; i < T_GAP + 1; i++) drive_cycle(1'b0, 1'b0);
    end
    // A single-mode session always uses MOTOR1 whatever the lead.
    drive_cycle(1'b1, 1'b0);
    obs = {MOTOR1, MOTOR2, OCUPADO};
    checks++;
    if (obs !== 3'b101) begin
      errors++;
      $display("FAIL lead_single got=%b expected=101", obs);
    end
    for (int i = 0; i < T_GAP + 1; i++) drive_cycle(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] obs;
    logic       arr;
    arr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) arr = ~arr;
      drive_cycle(arr, 1'($urandom_range(0, 1)));
      obs = {MOTOR1, MOTOR2, OCUPADO};
      checks++;
      if (obs !== model_out() || (MOTOR1 && MOTOR2)) begin
        errors++;
        $display("FAIL random cyc=%0d arr=%b got=%b expected=%b", i, arr, obs, model_out());
      end
    end
  endtask

  initial begin
    REINICIO = 1'b1;
    ARRANQUE = 1'b0;
    MODO     = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_stop_in_run_b();
    test_async_reset();
    test_lead();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
